// File: rtl/alu_hs_pkg.sv
// Shared definitions for the alu_hs block: FSM state type, group encoding,
// per-group operation encodings and a helper that classifies multi-cycle ops.
package alu_hs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Group select carried on the mode input
  localparam logic MODE_LOGIC = 1'b0;
  localparam logic MODE_ARITH = 1'b1;

  // Arithmetic group (mode = 1)
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_CMP = 3'd4;

  // Logical group (mode = 0)
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_NOT = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;
  localparam logic [2:0] OP_LSR = 3'd5;
  localparam logic [2:0] OP_ASR = 3'd6;

  // Operations that use the shared shift-add / restoring-divide engine
  function automatic logic is_iter_op(input logic mode, input logic [2:0] op);
    return (mode == MODE_ARITH) && ((op == OP_MUL) || (op == OP_DIV));
  endfunction

endpackage

// File: rtl/alu_hs_iter.sv
// Iterative multiply / divide engine shared by mul and div.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   start       load operands and begin DWIDTH iterations
//   is_div      1 = restoring divide, 0 = shift-add multiply (sampled on start)
//   a, b        multiplier/dividend and multiplicand/divisor (sampled on start)
//   last        high during the cycle whose rising edge performs the final step
//   result      {acc, shift register}: product, or {remainder, quotient}
module alu_hs_iter #(
  parameter int DWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_div,
  input  logic [DWIDTH-1:0]     a,
  input  logic [DWIDTH-1:0]     b,
  output logic                  last,
  output logic [2*DWIDTH-1:0]   result
);

  localparam int CW = $clog2(DWIDTH) + 1;

  logic [DWIDTH-1:0] acc_reg, sr_reg, b_reg;
  logic [DWIDTH-1:0] acc_next, sr_next;
  logic              div_reg, busy_reg;
  logic [CW-1:0]     cnt_reg;

  logic [DWIDTH:0]   sum;      // multiply: acc + (multiplicand if lsb set), with carry
  logic [DWIDTH:0]   shifted;  // divide: partial remainder shifted left by one
  logic [DWIDTH-1:0] diff;

  always_comb begin
    sum     = {1'b0, acc_reg} + (sr_reg[0] ? {1'b0, b_reg} : '0);
    shifted = {acc_reg, sr_reg[DWIDTH-1]};
    // Only used when shifted >= b, so the difference always fits in DWIDTH bits
    diff    = shifted[DWIDTH-1:0] - b_reg;
    acc_next = acc_reg;
    sr_next  = sr_reg;
    if (div_reg) begin
      if (shifted >= {1'b0, b_reg}) begin
        acc_next = diff;
        sr_next  = {sr_reg[DWIDTH-2:0], 1'b1};
      end else begin
        acc_next = shifted[DWIDTH-1:0];
        sr_next  = {sr_reg[DWIDTH-2:0], 1'b0};
      end
    end else begin
      // {carry, sum, multiplier} shifted right one place
      acc_next = sum[DWIDTH:1];
      sr_next  = {sum[0], sr_reg[DWIDTH-1:1]};
    end
  end

  assign last   = busy_reg && (cnt_reg == CW'(DWIDTH - 1));
  assign result = {acc_reg, sr_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg  <= '0;
      sr_reg   <= '0;
      b_reg    <= '0;
      div_reg  <= 1'b0;
      busy_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (start) begin
      acc_reg  <= '0;
      sr_reg   <= a;
      b_reg    <= b;
      div_reg  <= is_div;
      busy_reg <= 1'b1;
      cnt_reg  <= '0;
    end else if (busy_reg) begin
      acc_reg <= acc_next;
      sr_reg  <= sr_next;
      cnt_reg <= cnt_reg + 1'b1;
      if (last) busy_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_hs.sv
// Handshaked ALU: one request at a time, arithmetic and logical groups.
// Single-cycle ops are evaluated from the request as it is accepted and
// registered into dout; mul/div (non-zero din2) run DWIDTH steps in alu_hs_iter.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid / in_ready   request handshake (ready only in IDLE)
//   mode, op, din1, din2  request: group, operation, unsigned operands
//   out_valid / out_ready result handshake (valid only in DONE)
//   dout, err             result and error flag, qualified by out_valid
module alu_hs
  import alu_hs_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                mode,
  input  logic [2:0]          op,
  input  logic [DWIDTH-1:0]   din1,
  input  logic [DWIDTH-1:0]   din2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DWIDTH-1:0] dout,
  output logic                err
);

  localparam int SW = $clog2(DWIDTH);

  state_t               state_reg;
  logic                 in_ready_reg, out_valid_reg, err_reg, iter_src_reg;
  logic [2*DWIDTH-1:0]  dout_reg;

  logic                 accept, start_iter;
  logic [2*DWIDTH-1:0]  comb_result;
  logic                 comb_err;
  logic [DWIDTH-1:0]    logic_res;
  logic [SW-1:0]        shamt;

  logic                 iter_last;
  logic [2*DWIDTH-1:0]  iter_result;

  assign accept     = in_valid && in_ready_reg;
  // Mul/div by zero never enters CALC: mul gives 0, div gives its fixed result
  assign start_iter = accept && is_iter_op(mode, op) && (din2 != '0);
  assign shamt      = din2[SW-1:0];

  always_comb begin
    comb_result = '0;
    comb_err    = 1'b0;
    logic_res   = '0;
    if (mode == MODE_ARITH) begin
      case (op)
        OP_ADD: comb_result = {{DWIDTH{1'b0}}, din1} + {{DWIDTH{1'b0}}, din2};
        // Subtracting at full width yields the sign-extended difference
        OP_SUB: comb_result = {{DWIDTH{1'b0}}, din1} - {{DWIDTH{1'b0}}, din2};
        OP_MUL: comb_result = '0;
        OP_DIV: begin
          comb_result = {din1, {DWIDTH{1'b1}}};
          comb_err    = 1'b1;
        end
        OP_CMP: comb_result = {{(2*DWIDTH-3){1'b0}}, (din1 > din2), (din1 == din2), (din1 < din2)};
        default: comb_err = 1'b1;
      endcase
    end else begin
      case (op)
        OP_AND: logic_res = din1 & din2;
        OP_OR:  logic_res = din1 | din2;
        OP_XOR: logic_res = din1 ^ din2;
        OP_NOT: logic_res = ~din1;
        OP_SHL: logic_res = din1 << shamt;
        OP_LSR: logic_res = din1 >> shamt;
        OP_ASR: logic_res = $unsigned($signed(din1) >>> shamt);
        default: comb_err = 1'b1;
      endcase
      comb_result = {{DWIDTH{1'b0}}, logic_res};
    end
  end

  alu_hs_iter #(.DWIDTH(DWIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start_iter),
    .is_div (op == OP_DIV),
    .a      (din1),
    .b      (din2),
    .last   (iter_last),
    .result (iter_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      dout_reg      <= '0;
      err_reg       <= 1'b0;
      iter_src_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            in_ready_reg <= 1'b0;
            if (start_iter) begin
              state_reg    <= ST_CALC;
              iter_src_reg <= 1'b1;
              err_reg      <= 1'b0;
            end else begin
              state_reg     <= ST_DONE;
              out_valid_reg <= 1'b1;
              iter_src_reg  <= 1'b0;
              dout_reg      <= comb_result;
              err_reg       <= comb_err;
            end
          end
        end
        ST_CALC: begin
          if (iter_last) begin
            state_reg     <= ST_DONE;
            out_valid_reg <= 1'b1;
          end
        end
        ST_DONE: begin
          // A request arriving now is seen only once ready returns in IDLE
          if (out_ready) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  // The engine's registers hold the mul/div result untouched while in DONE
  assign dout      = iter_src_reg ? iter_result : dout_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_alu_hs.sv
// Self-checking bench for alu_hs (DWIDTH = 8): directed vector table,
// handshake corner sequences, and random ops against a reference model.
module tb_alu_hs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mode = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [7:0]  din1 = 8'd0, din2 = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] dout;
  logic        err;

  int checks = 0;
  int errors = 0;

  alu_hs #(.DWIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .op        (op),
    .din1      (din1),
    .din2      (din2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic [2:0]  o;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_d;
    logic        exp_e;
    int          exp_lat;
    string       nm;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, expv);
    end
  endtask

  // Reference model straight from the operation definitions, using integer arithmetic
  task automatic model(input int m, input int o, input int a, input int b,
                       output int d, output int e, output int lat);
    int sa, sh;
    d = 0; e = 0; lat = 1;
    sh = b % 8;
    if (m == 1) begin
      case (o)
        0: d = a + b;
        1: d = (a - b) & 16'hFFFF;
        2: begin d = a * b; lat = (b != 0) ? 9 : 1; end
        3: begin
          if (b == 0) begin d = a * 256 + 255; e = 1; end
          else begin d = (a % b) * 256 + (a / b); lat = 9; end
        end
        4: d = (a > b) ? 4 : ((a == b) ? 2 : 1);
        default: e = 1;
      endcase
    end else begin
      case (o)
        0: d = a & b;
        1: d = a | b;
        2: d = a ^ b;
        3: d = 255 - a;
        4: d = (a << sh) & 255;
        5: d = a >> sh;
        6: begin sa = (a >= 128) ? a - 256 : a; d = (sa >>> sh) & 255; end
        default: e = 1;
      endcase
    end
  endtask

  // One complete transaction: request, wait for result, check, acknowledge
  task automatic run_op(input logic m, input logic [2:0] o, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp_d,
                        input logic exp_e, input int exp_lat, input string nm);
    int lat;
    @(negedge clk);
    check({nm, " in_ready"}, 32'(in_ready), 32'd1);
    mode = m; op = o; din1 = a; din2 = b; in_valid = 1'b1;
    @(negedge clk);
    // Scramble the inputs to show the latched request is what gets computed
    in_valid = 1'b0; mode = ~m; op = o + 3'd1; din1 = ~a; din2 = ~b;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({nm, " latency"}, 32'(lat), 32'(exp_lat));
    check({nm, " dout"}, 32'(dout), 32'(exp_d));
    check({nm, " err"}, 32'(err), 32'(exp_e));
    $display("txn %s mode=%0d op=%0d a=%0h b=%0h -> dout=%04h err=%0d lat=%0d",
             nm, m, o, a, b, dout, err, lat);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] hold_d;
    bit          stable, ir_seen, ov_seen;
    int          rd, re, rl;
    int          rm, ro, ra, rb;

    vq.push_back('{1'b1, 3'd0, 8'd200, 8'd100, 16'h012C, 1'b0, 1, "add200+100"});
    vq.push_back('{1'b1, 3'd1, 8'd100, 8'd200, 16'hFF9C, 1'b0, 1, "sub100-200"});
    vq.push_back('{1'b1, 3'd4, 8'd5,   8'd9,   16'h0001, 1'b0, 1, "cmp5v9"});
    vq.push_back('{1'b1, 3'd4, 8'd9,   8'd9,   16'h0002, 1'b0, 1, "cmp9v9"});
    vq.push_back('{1'b1, 3'd4, 8'd10,  8'd9,   16'h0004, 1'b0, 1, "cmp10v9"});
    vq.push_back('{1'b0, 3'd6, 8'h80,  8'd3,   16'h00F0, 1'b0, 1, "asr80by3"});
    vq.push_back('{1'b1, 3'd2, 8'd255, 8'd255, 16'hFE01, 1'b0, 9, "mul255x255"});
    vq.push_back('{1'b1, 3'd3, 8'd200, 8'd7,   16'h041C, 1'b0, 9, "div200/7"});
    vq.push_back('{1'b1, 3'd3, 8'd13,  8'd0,   16'h0DFF, 1'b1, 1, "div13/0"});
    vq.push_back('{1'b1, 3'd2, 8'd7,   8'd0,   16'h0000, 1'b0, 1, "mul7x0"});
    vq.push_back('{1'b1, 3'd5, 8'd1,   8'd2,   16'h0000, 1'b1, 1, "arith_op5"});
    vq.push_back('{1'b0, 3'd7, 8'd1,   8'd2,   16'h0000, 1'b1, 1, "logic_op7"});
    vq.push_back('{1'b0, 3'd4, 8'h81,  8'd1,   16'h0002, 1'b0, 1, "shl81by1"});
    vq.push_back('{1'b0, 3'd3, 8'h0F,  8'd0,   16'h00F0, 1'b0, 1, "not0F"});
    vq.push_back('{1'b1, 3'd0, 8'd255, 8'd255, 16'h01FE, 1'b0, 1, "add255+255"});

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset dout", 32'(dout), 32'd0);
    check("reset err", 32'(err), 32'd0);

    foreach (vq[i])
      run_op(vq[i].m, vq[i].o, vq[i].a, vq[i].b, vq[i].exp_d, vq[i].exp_e, vq[i].exp_lat, vq[i].nm);

    // Result held for 5 cycles with out_ready low; a request pulse is ignored
    @(negedge clk);
    mode = 1'b1; op = 3'd0; din1 = 8'd10; din2 = 8'd20; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("hold out_valid", 32'(out_valid), 32'd1);
    hold_d = dout;
    stable = 1'b1; ir_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin in_valid = 1'b1; din1 = 8'd1; din2 = 8'd1; end
      else in_valid = 1'b0;
      @(negedge clk);
      if (dout !== hold_d || out_valid !== 1'b1) stable = 1'b0;
      if (in_ready) ir_seen = 1'b1;
    end
    in_valid = 1'b0;
    check("hold stable", 32'(stable), 32'd1);
    check("hold in_ready low", 32'(ir_seen), 32'd0);
    check("hold dout", 32'(dout), 32'd30);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold release in_ready", 32'(in_ready), 32'd1);
    check("hold release out_valid", 32'(out_valid), 32'd0);
    $display("txn hold add 10+20 held 5 cycles dout=%04h", hold_d);

    // Request arriving together with out_ready is taken on the following IDLE cycle
    mode = 1'b1; op = 3'd0; din1 = 8'd1; din2 = 8'd2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("overlap first dout", 32'(dout), 32'd3);
    out_ready = 1'b1; in_valid = 1'b1; din1 = 8'd50; din2 = 8'd60;
    @(negedge clk);
    out_ready = 1'b0;
    check("overlap not accepted in DONE", 32'(in_ready), 32'd1);
    check("overlap out_valid low", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("overlap second valid", 32'(out_valid), 32'd1);
    check("overlap second dout", 32'(dout), 32'd110);
    $display("txn overlap add 50+60 -> dout=%04h", dout);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during the fourth cycle of a divide aborts it
    mode = 1'b1; op = 3'd3; din1 = 8'd200; din2 = 8'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    ov_seen = out_valid;
    repeat (2) begin
      @(negedge clk);
      if (out_valid) ov_seen = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort dout", 32'(dout), 32'd0);
    check("abort err", 32'(err), 32'd0);
    repeat (12) begin
      if (out_valid) ov_seen = 1'b1;
      @(negedge clk);
    end
    check("abort out_valid never", 32'(ov_seen), 32'd0);
    $display("txn abort div 200/7 reset mid-calc out_valid_seen=%0d", ov_seen);
    run_op(1'b1, 3'd0, 8'd3, 8'd4, 16'h0007, 1'b0, 1, "add3+4_after_abort");

    // Random operations against the model
    for (int i = 0; i < 40; i++) begin
      rm = int'($urandom_range(0, 1));
      ro = int'($urandom_range(0, 7));
      ra = int'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      model(rm, ro, ra, rb, rd, re, rl);
      run_op(rm[0], ro[2:0], ra[7:0], rb[7:0], rd[15:0], re[0], rl, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_hs.md
ALU_HS -- requirements
Module: alu_hs

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, operand width in bits (minimum 4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port mode  input  1  1 = arithmetic group, 0 = logical group.
REQ-007 SHALL have port op  input  3  operation select within the group.
REQ-008 SHALL have ports din1 and din2  input  DWIDTH  unsigned operands.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port dout  output  2*DWIDTH  result.
REQ-012 SHALL have port err  output  1  error flag, qualified by out_valid.

Function
REQ-013 SHALL accept a request on any cycle where in_valid and in_ready are both 1, latching mode, op, din1 and din2.
REQ-014 SHALL ignore input changes after acceptance.
REQ-015 SHALL implement FSM states IDLE, CALC and DONE.
- IDLE->CALC on accept of mul or div with din2 != 0.
- IDLE->DONE on accept of any other op.
- CALC->DONE after DWIDTH iterations.
- DONE->IDLE when out_ready = 1.
REQ-016 SHALL drive in_ready = 1 only in IDLE, so operations never overlap.
REQ-017 SHALL drive out_valid = 1 only in DONE, holding dout and err stable until out_ready.
REQ-018 SHALL give a latency of 1 cycle from accept to out_valid for single-cycle ops, and DWIDTH+1 cycles for mul/div.
REQ-019 SHALL implement the arithmetic group (mode=1) as follows.
- op0 add: zero-extended din1+din2.
- op1 sub: din1-din2 in two's complement, sign-extended to 2*DWIDTH.
- op2 mul: iterative shift-add, full 2*DWIDTH product.
- op3 div: iterative restoring; dout = {remainder, quotient}.
- op4 compare: dout[2:0] = {gt, eq, lt}, upper bits 0.
- op5-op7: dout 0, err 1.
REQ-020 SHALL implement the logical group (mode=0) on DWIDTH bits, zero-extended to 2*DWIDTH, as follows.
- op0 and; op1 or; op2 xor; op3 not din1.
- op4 shl, op5 lsr, op6 asr: din1 shifted by din2[$clog2(DWIDTH)-1:0].
- op7: dout 0, err 1.
REQ-021 SHALL handle division by zero without iterating: quotient all ones, remainder din1, err 1, latency 1.
REQ-022 SHALL drive err = 0 for every valid op other than division by zero.
REQ-023 SHALL let a new request arrive in the same cycle as out_ready in DONE, but accept it only on the following IDLE cycle.

Reset
REQ-024 SHALL on rst force state IDLE, in_ready 1 on the next cycle, out_valid 0, dout 0, err 0, and clear the iteration counter and partial results.
REQ-025 SHALL treat rst asserted mid-operation (CALC or DONE) as an abort: the pending result is discarded and never presented.
REQ-026 SHALL give rst priority over in_valid and out_ready in the same cycle.

Structure
REQ-027 SHALL place the op encodings, the group encoding and the FSM state type in shared package alu_hs_pkg.
REQ-028 SHALL implement mul and div in one sub-module, alu_hs_iter, which has its own start/done, DWIDTH-cycle counter, and shared shift register and accumulator.
REQ-029 SHALL keep single-cycle ops combinational from the latched operands, registered into dout on entry to DONE.

Verification (DWIDTH=8)
REQ-030 SHALL cover add 200+100: dout 16'h012C, err 0, out_valid 1 cycle after accept.
REQ-031 SHALL cover sub 100-200: dout 16'hFF9C; compare 5 vs 9: dout 16'h0001; asr 8'h80 by 3: dout 16'h00F0.
REQ-032 SHALL cover mul 255*255: dout 16'hFE01 after 9 cycles; div 200/7: dout 16'h041C after 9 cycles.
REQ-033 SHALL cover div 13/0: dout 16'h0DFF, err 1, latency 1.
REQ-034 SHALL cover out_ready held low for 5 cycles after a result: dout stable, in_ready 0, an in_valid pulse ignored, then DONE->IDLE on out_ready.
REQ-035 SHALL cover rst asserted on cycle 4 of a divide: out_valid never rises, in_ready 1 on the next cycle, and a following add 3+4 returns 16'h0007.
